// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: FSM state type and default width for the bit-serial adder
package serial_adder_pkg;
  localparam int SERIAL_ADDER_WIDTH_DFLT = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} serial_adder_state_t;
endpackage

// File: rtl/serial_adder_ctrl_fa_bit.sv
// fa_bit: combinational one-bit full adder cell
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder sequencing one fa_bit over WIDTH cycles, LSB first.
// Define SERIAL_ADDER_SUB_EN to add the sub port (A-B with Carry=1 meaning no borrow).
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SERIAL_ADDER_WIDTH_DFLT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 1);
  serial_adder_state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             c_q, c_d, s, co, sub_l;
  logic [CW-1:0]    cnt_q, cnt_d;
`ifdef SERIAL_ADDER_SUB_EN
  assign sub_l = sub;
`else
  assign sub_l = 1'b0;
`endif
  fa_bit u_fa (.a(a_q[0]), .b(b_q[0]), .ci(c_q), .s(s), .co(co));
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE && in_valid) begin
      a_d     = A;
      b_d     = sub_l ? ~B : B;
      c_d     = sub_l | Cin;
      sum_d   = '0;
      cnt_d   = '0;
      state_d = RUN;
    end else if (state_q == RUN) begin
      a_d     = a_q >> 1;
      b_d     = b_q >> 1;
      c_d     = co;
      sum_d   = {s, sum_q[WIDTH-1:1]};
      cnt_d   = cnt_q + CW'(1);
      state_d = (cnt_q == CW'(WIDTH - 1)) ? DONE : RUN;
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      sum_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign Sum       = sum_q;
  assign Carry     = c_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: randomized self-checking bench against an arithmetic reference model
module tb_serial_adder_ctrl;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, Cin, sub_r, out_valid, out_ready, Carry, busy;
  logic [W-1:0] A, B, Sum;
  int pass = 0, total = 0;
  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Cin(Cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub_r),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .Sum(Sum), .Carry(Carry), .busy(busy)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  function automatic logic [W:0] model(input logic [W-1:0] a, b, input logic c, s);
    return s ? {a >= b, W'(a - b)} : {1'b0, a} + {1'b0, b} + (W+1)'(c);
  endfunction
  function automatic logic rand_sub();
`ifdef SERIAL_ADDER_SUB_EN
    return 1'($urandom_range(0, 1));
`else
    return 1'b0;
`endif
  endfunction
  task automatic run_op(input logic [W-1:0] a, b, input logic c, s, input bit take,
                        output int lat, output logic [W-1:0] sm, output logic cy);
    A = a; B = b; Cin = c; sub_r = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    sm = Sum;
    cy = Carry;
    if (take && lat > 0) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    total++; if ({in_ready, out_valid, busy} !== 3'b100) $display("FAIL reset_flags: got %b want 100", {in_ready, out_valid, busy}); else pass++;
    total++; if ({Carry, Sum} !== 9'h0) $display("FAIL reset_result: got %h want 000", {Carry, Sum}); else pass++;
  endtask
  task automatic test_directed();
    logic [W-1:0] va[3] = '{8'h35, 8'hFF, 8'hFF};
    logic [W-1:0] vb[3] = '{8'h4A, 8'h01, 8'hFF};
    logic         vc[3] = '{1'b0, 1'b0, 1'b1};
    logic [W:0]   want[3] = '{9'h07F, 9'h100, 9'h1FF};
    int lat;
    logic [W-1:0] sm;
    logic cy;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], vc[i], 1'b0, 1'b1, lat, sm, cy);
      total++; if (lat != W) $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, W); else pass++;
      total++; if ({cy, sm} !== want[i]) $display("FAIL directed_result[%0d]: got %h want %h", i, {cy, sm}, want[i]); else pass++;
      total++; if (!in_ready || out_valid) $display("FAIL directed_idle[%0d]: in_ready=%b out_valid=%b want 1 0", i, in_ready, out_valid); else pass++;
    end
  endtask
  task automatic test_random();
    int lat;
    logic [W-1:0] a, b, sm;
    logic c, s, cy;
    logic [W:0] want;
    for (int i = 0; i < 25; i++) begin
      a = W'($urandom); b = W'($urandom); c = 1'($urandom); s = rand_sub();
      want = model(a, b, c, s);
      run_op(a, b, c, s, 1'b1, lat, sm, cy);
      total++; if (lat != W || {cy, sm} !== want) $display("FAIL random[%0d]: a=%h b=%h c=%b sub=%b got %h lat %0d want %h lat %0d", i, a, b, c, s, {cy, sm}, lat, want, W); else pass++;
    end
  endtask
  task automatic test_backpressure();
    int lat, bad;
    logic [W-1:0] sm;
    logic cy;
    run_op(8'hA5, 8'h3C, 1'b1, 1'b0, 1'b0, lat, sm, cy);
    total++; if ({cy, sm} !== 9'h0E2) $display("FAIL bp_result: got %h want 0e2", {cy, sm}); else pass++;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      A = W'($urandom); B = W'($urandom); Cin = 1'($urandom); in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (!out_valid || in_ready || !busy || Sum !== sm || Carry !== cy) bad++;
    end
    total++; if (bad != 0) $display("FAIL bp_hold: got %0d unstable cycles want 0", bad); else pass++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++; if ({in_ready, out_valid, busy} !== 3'b100) $display("FAIL bp_release: got %b want 100", {in_ready, out_valid, busy}); else pass++;
    @(posedge clk); #1;
    total++; if ({in_ready, out_valid, busy} !== 3'b100) $display("FAIL bp_no_queue: got %b want 100", {in_ready, out_valid, busy}); else pass++;
  endtask
  task automatic test_back_to_back();
    logic [W:0] exp_q[$];
    int acc_t[$];
    int nres = 0, bad = 0;
    bit acc, done;
    logic s;
    A = W'($urandom); B = W'($urandom); Cin = 1'($urandom); s = rand_sub(); sub_r = s;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 100; cyc++) begin
      acc = in_ready && in_valid;
      done = out_valid && out_ready;
      if (done) begin
        nres++;
        if (exp_q.size() == 0 || {Carry, Sum} !== exp_q[0]) begin
          bad++;
          $display("FAIL b2b_result[%0d]: got %h want %h", nres, {Carry, Sum}, exp_q.size() ? exp_q[0] : 'x);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (acc) begin
        exp_q.push_back(model(A, B, Cin, s));
        acc_t.push_back(cyc);
      end
      @(posedge clk); #1;
      if (acc) begin
        A = W'($urandom); B = W'($urandom); Cin = 1'($urandom); s = rand_sub(); sub_r = s;
        if (acc_t.size() == 5) in_valid = 1'b0;
      end
      if (acc_t.size() == 5 && exp_q.size() == 0) break;
    end
    out_ready = 1'b0;
    total++; if (nres != 5 || bad != 0) $display("FAIL b2b_results: got %0d results %0d wrong want 5 results 0 wrong", nres, bad); else pass++;
    for (int i = 1; i < acc_t.size(); i++) begin
      total++; if (acc_t[i] - acc_t[i-1] != W + 2) $display("FAIL b2b_spacing[%0d]: got %0d want %0d", i, acc_t[i] - acc_t[i-1], W + 2); else pass++;
    end
  endtask
  task automatic test_mid_reset();
    int lat, seen;
    logic [W-1:0] sm;
    logic cy;
    A = 8'h12; B = 8'h34; Cin = 1'b0; sub_r = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if ({in_ready, out_valid, busy, Carry, Sum} !== {3'b100, 9'h0}) $display("FAIL midrst_state: got %b %h want 100 000", {in_ready, out_valid, busy}, {Carry, Sum}); else pass++;
    out_ready = 1'b1;
    seen = 0;
    repeat (W + 4) begin
      @(posedge clk); #1;
      if (out_valid || busy) seen++;
    end
    out_ready = 1'b0;
    total++; if (seen != 0) $display("FAIL midrst_discard: got %0d active cycles want 0", seen); else pass++;
    run_op(8'h12, 8'h34, 1'b0, 1'b0, 1'b1, lat, sm, cy);
    total++; if (lat != W || {cy, sm} !== 9'h046) $display("FAIL midrst_next: got %h lat %0d want 046 lat %0d", {cy, sm}, lat, W); else pass++;
  endtask
`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    int lat;
    logic [W-1:0] sm;
    logic cy;
    run_op(8'h10, 8'h03, 1'b0, 1'b1, 1'b1, lat, sm, cy);
    total++; if ({cy, sm} !== 9'h10D) $display("FAIL sub_no_borrow: got %h want 10d", {cy, sm}); else pass++;
    run_op(8'h03, 8'h10, 1'b1, 1'b1, 1'b1, lat, sm, cy);
    total++; if ({cy, sm} !== 9'h0F3) $display("FAIL sub_borrow: got %h want 0f3", {cy, sm}); else pass++;
  endtask
`endif
  initial begin
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; Cin = 1'b0; sub_r = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial adder controller: accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake. It sequences a single one-bit full-adder cell across WIDTH cycles, LSB first, and returns Sum and Carry over a second valid/ready handshake. It sits beside the parallel adders as the area-minimal option, trading latency for one adder cell.

## Interface

Parameters:
- WIDTH, 8, operand/result width; legal range 2..64.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands presented.
- in_ready  output  1  block can accept operands.
- A  input  WIDTH  operand A; sampled on input handshake only.
- B  input  WIDTH  operand B; sampled on input handshake only.
- Cin  input  1  carry-in; sampled on input handshake only.
- sub  input  1  subtract select; present only with SERIAL_ADDER_SUB_EN.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- Sum  output  WIDTH  result bits.
- Carry  output  1  carry-out of MSB.
- busy  output  1  high in RUN or DONE.

## Operation

- The FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready, load A and B into operand shift registers and Cin into the carry register.
  - Clear the bit counter and the Sum shift register, then go to RUN.
- RUN: each cycle, apply a[0], b[0] and the carry register to the adder cell.
  - Shift the operand registers right by 1.
  - Shift the cell sum into Sum from the MSB side, moving earlier bits right.
  - Load the cell carry-out into the carry register and increment the counter.
  - After the WIDTH-th bit, go to DONE.
- DONE:
  - out_valid=1; Sum and Carry are held stable.
  - On out_ready, return to IDLE.
- in_ready=0 in RUN and DONE. in_valid is ignored there; it is not queued.
- Arithmetic is unsigned modulo 2^WIDTH; Carry is bit WIDTH of A+B+Cin.
- The counter is $clog2(WIDTH+1) bits wide. The terminal value WIDTH must never wrap.
- Sum and Carry are only meaningful while out_valid=1. During RUN they show partial shift contents.
- A new operation clears Sum only at acceptance. Sum keeps its last value in IDLE.
- Reset, at any time including mid-RUN or DONE:
  - state=IDLE, in_ready=1, out_valid=0, busy=0, Sum=0, Carry=0, counter=0.
  - Any in-flight operation is discarded with no output.

## Timing

- Call the input-handshake edge E0.
- Bits 0..WIDTH-1 are processed on edges E1..EWIDTH.
- out_valid is high in the cycle following EWIDTH, i.e. WIDTH cycles after the handshake cycle.
- The output handshake edge returns the FSM to IDLE. in_ready is high the next cycle.
- Minimum issue interval is WIDTH+2 cycles with out_ready held high.
- No combinational path from in_valid to in_ready or from out_ready to out_valid. All outputs are registered or decoded from state only.

## Configuration

- SERIAL_ADDER_SUB_EN defined:
  - The sub port exists and is sampled at input handshake.
  - sub=1: B is loaded inverted and the carry register is loaded with 1; Cin is ignored.
  - The result is A−B mod 2^WIDTH, with Carry=1 meaning no borrow (A≥B).
  - sub=0: behaves as plain add.
- Undefined: the sub port is absent; add-only behaviour as above.

## Structure

- Package serial_adder_pkg:
  - state enum typedef serial_adder_state_t {IDLE, RUN, DONE}.
  - Default width constant SERIAL_ADDER_WIDTH_DFLT=8.
- One sub-module, fa_bit:
  - Combinational 1-bit full adder with inputs a, b, ci and outputs s, co.
  - Instantiated once, inside the datapath.
- FSM, counter and shift registers live in serial_adder_ctrl.

## Test plan

All scenarios use WIDTH=8.

- A=35h, B=4Ah, Cin=0 -> Sum=7Fh, Carry=0; out_valid rises exactly 8 cycles after the handshake cycle.
- A=FFh, B=01h, Cin=0 -> Sum=00h, Carry=1. Then A=FFh, B=FFh, Cin=1 -> Sum=FFh, Carry=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE. Sum/Carry are stable, in_ready=0, and pulses on in_valid are ignored. Raise out_ready -> IDLE next cycle.
- Back-to-back: keep in_valid=1 with new operands and out_ready=1. Accepts are spaced exactly 10 cycles apart, and every result is correct.
- Assert rst for one cycle after bit 3 of A=12h, B=34h. Next cycle all outputs are at reset values with in_ready=1. A following op A=12h, B=34h gives Sum=46h, Carry=0.
- With SERIAL_ADDER_SUB_EN: A=10h, B=03h, sub=1 -> Sum=0Dh, Carry=1. A=03h, B=10h, sub=1 -> Sum=F3h, Carry=0.
